// File: rtl/dec_onehot_seq.sv
// rtl/dec_onehot_seq.sv - registered one-hot channel decoder with direct load and auto-scan
module dec_onehot_seq #(
   parameter int N_OUT    = 6,
   parameter int SEL_W    = 3,
   parameter int SCAN_DIV = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [SEL_W-1:0] a,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [N_OUT-1:0] y,
   output logic [SEL_W-1:0] idx,
   output logic             wrap,
   output logic             err
);

   localparam int DW_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   typedef enum logic [1:0] {
      M_DIRECT    = 2'b00,
      M_SCAN_UP   = 2'b01,
      M_SCAN_DOWN = 2'b10,
      M_HOLD      = 2'b11
   } mode_t;

   mode_t            cur_mode;
   mode_t            prev_mode;
   logic [DW_W-1:0]  dwell;
   logic [DW_W-1:0]  dwell_nxt;
   logic [SEL_W-1:0] idx_nxt;
   logic             wrap_nxt;
   logic             err_nxt;
   logic             transfer;
   logic             mode_chg;
   logic             dwell_done;
   logic             a_in_range;

   assign cur_mode   = mode_t'(mode);
   assign in_ready   = en & (cur_mode == M_DIRECT);
   assign transfer   = in_valid & in_ready;
   assign mode_chg   = (cur_mode != prev_mode);
   assign dwell_done = (dwell == DW_W'(SCAN_DIV - 1));
   // Compare in SEL_W+1 bits so N_OUT == 2**SEL_W does not truncate to zero.
   assign a_in_range = ({1'b0, a} < (SEL_W + 1)'(N_OUT));

   // Next channel, dwell and event pulses for an enabled cycle.
   always_comb begin
      idx_nxt   = idx;
      dwell_nxt = dwell;
      wrap_nxt  = 1'b0;
      err_nxt   = 1'b0;
      case (cur_mode)
         M_DIRECT: begin
            if (transfer) begin
               if (a_in_range) idx_nxt = a;
               else            err_nxt = 1'b1;
            end
         end
         M_SCAN_UP: begin
            if (!mode_chg) begin
               if (dwell_done) begin
                  dwell_nxt = '0;
                  if (idx == SEL_W'(N_OUT - 1)) begin
                     idx_nxt  = '0;
                     wrap_nxt = 1'b1;
                  end else begin
                     idx_nxt = idx + SEL_W'(1);
                  end
               end else begin
                  dwell_nxt = dwell + DW_W'(1);
               end
            end
         end
         M_SCAN_DOWN: begin
            if (!mode_chg) begin
               if (dwell_done) begin
                  dwell_nxt = '0;
                  if (idx == '0) begin
                     idx_nxt  = SEL_W'(N_OUT - 1);
                     wrap_nxt = 1'b1;
                  end else begin
                     idx_nxt = idx - SEL_W'(1);
                  end
               end else begin
                  dwell_nxt = dwell + DW_W'(1);
               end
            end
         end
         default: ;
      endcase
      // A mode change restarts the dwell and suppresses stepping that cycle.
      if (mode_chg) dwell_nxt = '0;
   end

   // Register state and outputs; disabled cycles blank y and freeze the scan.
   always_ff @(posedge clk) begin
      if (rst) begin
         y         <= '0;
         idx       <= '0;
         wrap      <= 1'b0;
         err       <= 1'b0;
         dwell     <= '0;
         prev_mode <= M_DIRECT;
      end else if (!en) begin
         y    <= '0;
         wrap <= 1'b0;
         err  <= 1'b0;
      end else begin
         idx       <= idx_nxt;
         dwell     <= dwell_nxt;
         prev_mode <= cur_mode;
         y         <= {{(N_OUT - 1){1'b0}}, 1'b1} << idx_nxt;
         wrap      <= wrap_nxt;
         err       <= err_nxt;
      end
   end

endmodule
